// File: rtl/qea_loader_pkg.sv
// Shared types, error codes and helpers for the QEA host loader.
// Used by qea_host_loader and qea_state_init_gen.
package qea_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CTX_LOAD,
        STATE_INIT,
        START,
        RUN,
        DONE
    } loader_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_STREAM  = 2'd1;
    localparam logic [1:0] ERR_QBIT    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Fixed-point 1.0 for a real/imag half of an amplitude.
    function automatic logic [31:0] fixed_one(input int frac_bits);
        return 32'd1 << frac_bits;
    endfunction

    // PE_NUM = 4 lanes per row, so 2**q amplitudes occupy 2**(q-2) rows.
    function automatic logic [31:0] row_count(input int qbit_num);
        return 32'd1 << (qbit_num - 2);
    endfunction

endpackage

// File: rtl/qea_state_init_gen.sv
// Writes the |0...0> initial state into the QEA state RAM, one row per cycle.
// A one-cycle start pulse launches it; done pulses with the last row write.
module qea_state_init_gen
    import qea_loader_pkg::*;
#(
    parameter int PE_NUM           = 4,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT     = 30
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [MAX_QBIT_WIDTH-1:0]          qbit_num,
    output logic                               state_ena,
    output logic                               state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] state_dina,
    output logic                               done
);

    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
    localparam logic [31:0] ONE = fixed_one(NUM_FRAC_BIT);
    // Amplitude 1.0 + 0j sits in the upper (real) half of the top lane.
    localparam logic [ROW_W-1:0] ROW0 = {ONE, {(ROW_W - 32){1'b0}}};

    logic        active;
    logic [31:0] row;
    logic [31:0] last_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active      <= 1'b0;
            row         <= '0;
            last_row    <= '0;
            state_ena   <= 1'b0;
            state_wea   <= 1'b0;
            state_addra <= '0;
            state_dina  <= '0;
            done        <= 1'b0;
        end else begin
            state_ena <= 1'b0;
            state_wea <= 1'b0;
            done      <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                row      <= '0;
                last_row <= row_count(32'(qbit_num)) - 32'd1;
            end else if (active) begin
                state_ena   <= 1'b1;
                state_wea   <= 1'b1;
                state_addra <= row[STATE_ADDR_WIDTH-1:0];
                state_dina  <= (row == 32'd0) ? ROW0 : '0;
                row         <= row + 32'd1;
                if (row == last_row) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/qea_host_loader.sv
// Loads QEA context RAM from a stream, initialises state RAM, runs QEA and times it.
// Optional watchdog in RUN: define QEA_LOADER_TIMEOUT_EN.
module qea_host_loader
    import qea_loader_pkg::*;
#(
    parameter int PE_NUM                  = 4,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int TIMEOUT_CYCLES          = 2**20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [63:0]                        s_data,
    input  logic                               s_last,
    output logic                               o_ctx_en,
    output logic                               o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
    output logic                               o_state_ena,
    output logic                               o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
    output logic                               o_start,
    input  logic                               i_complete,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_err,
    output logic [1:0]                         o_err_code,
    output logic [31:0]                        o_cycles,
    output logic [2:0]                         o_dbg_state
);

    // Stream handshake: s_ready is registered and high for all of CTX_LOAD;
    // a word transfers on every rising edge where s_valid && s_ready.
    loader_state_t                      state;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt_nxt;
    logic [31:0]                        run_cnt;
    logic                               complete_q;
    logic                               handshake;
    logic                               gen_start;
    logic                               gen_done;

    assign handshake   = s_valid & s_ready;
    assign ctx_cnt_nxt = ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
    assign o_busy      = (state != IDLE);
    assign o_dbg_state = state;

    qea_state_init_gen #(
        .PE_NUM           (PE_NUM),
        .MAX_QBIT_WIDTH   (MAX_QBIT_WIDTH),
        .STATE_DATA_WIDTH (STATE_DATA_WIDTH),
        .STATE_ADDR_WIDTH (STATE_ADDR_WIDTH),
        .NUM_FRAC_BIT     (NUM_FRAC_BIT)
    ) u_state_init (
        .clk         (clk),
        .rst         (rst),
        .start       (gen_start),
        .qbit_num    (qbit_q),
        .state_ena   (o_state_ena),
        .state_wea   (o_state_wea),
        .state_addra (o_state_addra),
        .state_dina  (o_state_dina),
        .done        (gen_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            qbit_q     <= '0;
            ins_q      <= '0;
            ctx_cnt    <= '0;
            run_cnt    <= '0;
            complete_q <= 1'b0;
            gen_start  <= 1'b0;
            s_ready    <= 1'b0;
            o_ctx_en   <= 1'b0;
            o_ctx_wea  <= 1'b0;
            o_ctx_addr <= '0;
            o_ctx_data <= '0;
            o_start    <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
            o_cycles   <= '0;
        end else begin
            complete_q <= i_complete;
            o_ctx_en   <= 1'b0;
            o_ctx_wea  <= 1'b0;
            o_start    <= 1'b0;
            o_done     <= 1'b0;
            gen_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_go) begin
                        qbit_q     <= i_qbit_num;
                        ins_q      <= i_ins_num;
                        ctx_cnt    <= '0;
                        o_err      <= 1'b0;
                        o_err_code <= ERR_NONE;
                        if (i_qbit_num < MAX_QBIT_WIDTH'(2)) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_QBIT;
                            o_done     <= 1'b1;
                        end else if (i_ins_num == '0) begin
                            gen_start <= 1'b1;
                            state     <= STATE_INIT;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= CTX_LOAD;
                        end
                    end
                end
                CTX_LOAD: begin
                    if (handshake) begin
                        o_ctx_en   <= 1'b1;
                        o_ctx_wea  <= 1'b1;
                        o_ctx_addr <= ctx_cnt;
                        o_ctx_data <= s_data;
                        ctx_cnt    <= ctx_cnt_nxt;
                        // Stream must end exactly on the configured word count.
                        if ((ctx_cnt_nxt == ins_q) || s_last) begin
                            s_ready <= 1'b0;
                            if ((ctx_cnt_nxt == ins_q) && s_last) begin
                                gen_start <= 1'b1;
                                state     <= STATE_INIT;
                            end else begin
                                o_err      <= 1'b1;
                                o_err_code <= ERR_STREAM;
                                state      <= DONE;
                            end
                        end
                    end
                end
                STATE_INIT: begin
                    if (gen_done) state <= START;
                end
                START: begin
                    o_start <= 1'b1;
                    run_cnt <= 32'd1;
                    state   <= RUN;
                end
                RUN: begin
                    // Only a fresh rising edge ends the run; a stale high level does not.
                    if (i_complete && !complete_q) begin
                        o_cycles <= run_cnt;
                        state    <= DONE;
                    end
`ifdef QEA_LOADER_TIMEOUT_EN
                    else if (run_cnt >= 32'(TIMEOUT_CYCLES)) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TIMEOUT;
                        o_cycles   <= 32'(TIMEOUT_CYCLES);
                        state      <= DONE;
                    end
`endif
                    else if (run_cnt != 32'hFFFF_FFFF) begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_host_loader.sv
// Directed bench for qea_host_loader: stream loads, state init, run timing,
// stream/qbit errors, stale completion and asynchronous reset abort.
module tb_qea_host_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_go;
    logic [5:0]    i_qbit_num;
    logic [15:0]   i_ins_num;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_data;
    logic          s_last;
    logic          o_ctx_en;
    logic          o_ctx_wea;
    logic [15:0]   o_ctx_addr;
    logic [63:0]   o_ctx_data;
    logic          o_state_ena;
    logic          o_state_wea;
    logic [15:0]   o_state_addra;
    logic [255:0]  o_state_dina;
    logic          o_start;
    logic          i_complete;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [1:0]    o_err_code;
    logic [31:0]   o_cycles;
    logic [2:0]    o_dbg_state;

    localparam logic [255:0] ROW0 = {32'h4000_0000, 224'h0};

    int checks = 0;
    int errors = 0;
    int ctx_writes, state_writes, start_cnt, done_cnt;
    int mon_ctx_addr, mon_state_row;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    qea_host_loader dut (
        .clk           (clk),
        .rst           (rst),
        .i_go          (i_go),
        .i_qbit_num    (i_qbit_num),
        .i_ins_num     (i_ins_num),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .o_ctx_en      (o_ctx_en),
        .o_ctx_wea     (o_ctx_wea),
        .o_ctx_addr    (o_ctx_addr),
        .o_ctx_data    (o_ctx_data),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .o_state_dina  (o_state_dina),
        .o_start       (o_start),
        .i_complete    (i_complete),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_err_code    (o_err_code),
        .o_cycles      (o_cycles),
        .o_dbg_state   (o_dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Scoreboard for RAM-side writes seen on one negedge.
    task automatic observe();
        if (o_ctx_en && o_ctx_wea) begin
            ctx_writes++;
            chk("ctx_addr", 64'(o_ctx_addr), 64'(mon_ctx_addr));
            chk("ctx_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("ctx_data", o_ctx_data, exp_q.pop_front());
            mon_ctx_addr++;
        end
        if (o_state_ena && o_state_wea) begin
            state_writes++;
            chk("state_addr", 64'(o_state_addra), 64'(mon_state_row));
            checks++;
            assert (o_state_dina === ((mon_state_row == 0) ? ROW0 : 256'h0)) else begin
                errors++;
                $display("FAIL state_row%0d observed=%0h expected_row0=%0d", mon_state_row,
                         o_state_dina, (mon_state_row == 0));
                $error("check state_row");
            end
            mon_state_row++;
        end
        if (o_start) start_cnt++;
        if (o_done) done_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
    endtask

    task automatic new_seq();
        exp_q.delete();
        mon_ctx_addr  = 0;
        mon_state_row = 0;
        ctx_writes    = 0;
        state_writes  = 0;
        start_cnt     = 0;
        done_cnt      = 0;
    endtask

    task automatic go(input logic [5:0] q, input logic [15:0] ins);
        tick();
        i_go       = 1'b1;
        i_qbit_num = q;
        i_ins_num  = ins;
        tick();
        i_go = 1'b0;
    endtask

    task automatic send_words(input int n, input int last_at, input bit rand_valid);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 2000) begin
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = {$urandom, $urandom};
            s_last  = (idx == last_at);
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                idx++;
            end
            tick();
            guard++;
        end
        chk("send_count", 64'(idx), 64'(n));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int g = 0;
        while (!o_start && g < budget) begin
            tick();
            g++;
        end
        chk("start_seen", 64'(o_start), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        while (!o_done && g < budget) begin
            tick();
            g++;
        end
        chk("done_seen", 64'(o_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        i_go       = 1'b0;
        i_qbit_num = '0;
        i_ins_num  = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        i_complete = 1'b0;
        new_seq();
        #1 rst = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_ctx_en", 64'(o_ctx_en), 64'd0);
        chk("rst_state_ena", 64'(o_state_ena), 64'd0);
        chk("rst_start", 64'(o_start), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_cycles", 64'(o_cycles), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(o_busy), 64'd0);
        chk("idle_done", 64'(o_done), 64'd0);

        // 151 words, qbit 3, completion 40 cycles into the run
        new_seq();
        go(6'd3, 16'd151);
        chk("t1_busy", 64'(o_busy), 64'd1);
        send_words(151, 150, 1'b0);
        wait_start(50);
        repeat (39) tick();
        i_complete = 1'b1;
        wait_done(20);
        chk("t1_cycles", 64'(o_cycles), 64'd40);
        chk("t1_err", 64'(o_err), 64'd0);
        chk("t1_code", 64'(o_err_code), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(o_done), 64'd0);
        chk("t1_idle", 64'(o_busy), 64'd0);
        chk("t1_ctx_writes", 64'(ctx_writes), 64'd151);
        chk("t1_state_writes", 64'(state_writes), 64'd2);
        chk("t1_starts", 64'(start_cnt), 64'd1);
        chk("t1_dones", 64'(done_cnt), 64'd1);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // ins_num 10 but s_last on word index 7
        new_seq();
        go(6'd4, 16'd10);
        send_words(8, 7, 1'b0);
        wait_done(20);
        chk("t3_err", 64'(o_err), 64'd1);
        chk("t3_code", 64'(o_err_code), 64'd1);
        chk("t3_ready", 64'(s_ready), 64'd0);
        chk("t3_cycles_kept", 64'(o_cycles), 64'd40);
        repeat (3) tick();
        chk("t3_ctx_writes", 64'(ctx_writes), 64'd8);
        chk("t3_state_writes", 64'(state_writes), 64'd0);
        chk("t3_starts", 64'(start_cnt), 64'd0);

        // Random s_valid, 16 words, qbit 6; i_complete still high from earlier
        new_seq();
        go(6'd6, 16'd16);
        chk("t2_err_cleared", 64'(o_err), 64'd0);
        chk("t2_code_cleared", 64'(o_err_code), 64'd0);
        send_words(16, 15, 1'b1);
        wait_start(60);
        repeat (19) tick();
        chk("t2_no_early_exit", 64'(done_cnt), 64'd0);
        chk("t2_busy_run", 64'(o_busy), 64'd1);
        i_complete = 1'b0;
        repeat (5) tick();
        i_complete = 1'b1;
        wait_done(20);
        chk("t2_cycles", 64'(o_cycles), 64'd25);
        chk("t2_err", 64'(o_err), 64'd0);
        chk("t2_ctx_writes", 64'(ctx_writes), 64'd16);
        chk("t2_state_writes", 64'(state_writes), 64'd16);
        chk("t2_starts", 64'(start_cnt), 64'd1);

        // qbit 1 rejected immediately
        new_seq();
        go(6'd1, 16'd5);
        chk("t4_done", 64'(o_done), 64'd1);
        chk("t4_err", 64'(o_err), 64'd1);
        chk("t4_code", 64'(o_err_code), 64'd2);
        chk("t4_busy", 64'(o_busy), 64'd0);
        tick();
        chk("t4_done_pulse", 64'(o_done), 64'd0);
        chk("t4_err_sticky", 64'(o_err), 64'd1);
        repeat (3) tick();
        chk("t4_ctx_writes", 64'(ctx_writes), 64'd0);
        chk("t4_state_writes", 64'(state_writes), 64'd0);
        chk("t4_starts", 64'(start_cnt), 64'd0);

        // Reset mid CTX_LOAD after 5 words, then a clean rerun
        i_complete = 1'b0;
        new_seq();
        go(6'd3, 16'd20);
        send_words(5, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_s_ready", 64'(s_ready), 64'd0);
        chk("t6_ctx_en", 64'(o_ctx_en), 64'd0);
        chk("t6_ctx_addr", 64'(o_ctx_addr), 64'd0);
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_err", 64'(o_err), 64'd0);
        chk("t6_code", 64'(o_err_code), 64'd0);
        chk("t6_cycles", 64'(o_cycles), 64'd0);
        repeat (3) tick();
        chk("t6_ctx_writes", 64'(ctx_writes), 64'd5);
        chk("t6_state_writes", 64'(state_writes), 64'd0);
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        rst = 1'b0;
        new_seq();
        go(6'd2, 16'd3);
        chk("t6b_busy", 64'(o_busy), 64'd1);
        send_words(3, 2, 1'b0);
        wait_start(20);
        repeat (4) tick();
        i_complete = 1'b1;
        wait_done(20);
        chk("t6b_cycles", 64'(o_cycles), 64'd5);
        chk("t6b_ctx_writes", 64'(ctx_writes), 64'd3);
        chk("t6b_state_writes", 64'(state_writes), 64'd1);
        chk("t6b_starts", 64'(start_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
